mips_byte_mem_responder: RTL and testbench
==========================================

Name: mips_byte_mem_responder

Overview:
- External-side memory responder for the 8-bit TinyTapeOut byte bus driven by the MIPS IO controller.
- Serves 32-bit instruction words byte-serially from an internal program counter.
- Captures 4-byte address/data words for stores, loads and jumps, and serves 4-byte load data back.
- Used in the chip-level testbench and in the FPGA host bridge; holds a unified word memory that is preloadable through a host port.

Parameters:
DEPTH, 256, number of 32-bit words in memory (power of two).
AW, 8, word-index width, equal to log2(DEPTH).

Ports:
clk  in  1  single clock.
rst  in  1  synchronous, active-high reset.
phase  in  3  controller phase: 000 PREPARE, 001 FETCH, 010 EXECUTE, 011 GET_WORD, 100 WRITE_WORD, 101 STALL; 110 and 111 are illegal.
cmd  in  2  transfer kind, valid from EXECUTE through end of GET_WORD: 00 none, 01 store, 10 load, 11 jump.
addr_in  in  8  address byte lane (controller address_out).
data_in  in  8  store-data byte lane (controller data_output).
data_out  out  8  byte lane to controller data_input; combinational from internal state and memory.
ld_en  in  1  host preload write strobe.
ld_addr  in  AW  host preload word index.
ld_data  in  32  host preload word.
pc  out  32  current instruction byte address.
proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=1 at posedge): pc=0, proto_err=0, byte counter=0, capture registers=0, FSM=IDLE. Memory contents are preserved.
- Internal FSM: IDLE, FETCH, CAPTURE, SERVE. Byte counter cnt is 3 bits.
- IDLE:
  - Entered on phase PREPARE or EXECUTE; cnt cleared to 0.
  - data_out=0x00.
  - ld_en writes mem[ld_addr]=ld_data. ld_en in any other state is ignored and sets proto_err.
- FETCH (phase=001):
  - data_out = byte cnt of mem[pc[AW+1:2]], LSB first, for cnt 0..3. data_out=0x00 for cnt>=4.
  - cnt increments each cycle, saturating at 4.
  - On the first non-FETCH phase after cnt reached 4: pc <= pc+4, modulo 2^32.
  - Leaving FETCH with cnt<4 sets proto_err; pc is unchanged.
- CAPTURE (phase=011):
  - On cycle cnt (0..3), the bytes are written into the capture registers: addr_in into addr_q[8*cnt +: 8] and data_in into data_q[8*cnt +: 8]. data_out=0x00.
  - At the end of the cycle with cnt=3, cmd is acted on:
    - store: mem[addr_q[AW+1:2]] <= data_q, using the completed values including byte 3.
    - jump: pc <= completed addr_q. This overrides the pending +4 from the same instruction's fetch, which has already been applied.
    - load: the loaded word is latched into rd_q from mem at the completed address, and cnt resets to 0.
    - none: the transfer is ignored and proto_err is set.
  - A fifth GET_WORD cycle sets proto_err and writes nothing.
- STALL (phase=101):
  - Address lane is ignored (the controller drives 0xFF here).
  - cnt=0 and data_out=0x00.
  - Legal only after a load capture; otherwise sets proto_err.
- SERVE (phase=100):
  - data_out = rd_q[8*cnt +: 8] for cnt 0..3, and 0x00 when cnt=4. cnt saturates at 4.
  - The 5th cycle is the controller's exit cycle and is not an error.
- Addressing:
  - Word index is addr[AW+1:2]; upper bits wrap modulo DEPTH.
  - addr[1:0] is ignored; only word access is supported.
- Illegal phase (110/111): FSM goes to IDLE and proto_err is set.
- Reset mid-transfer: all partial captures are discarded, and no store is committed unless its cnt=3 edge completed before reset.
- Simultaneous ld_en and a store to the same index: the store wins. This can only occur alongside an error.
- proto_err clears only on rst.

Test Plan:
- Preload mem[0]=0x8C220004, mem[1]=0x00000000; reset; phase FETCH for 5 cycles -> data_out 04,00,22,8C,00; after phase goes to EXECUTE, pc=4.
- Store: cmd=01, GET_WORD bytes addr 10,00,00,00 and data 78,56,34,12 -> mem[4]=0x12345678, proto_err=0.
- Load: mem[4]=0xCAFEBABE; cmd=10, GET_WORD address 0x00000010, then STALL, then WRITE_WORD for 5 cycles -> data_out BE,BA,FE,CA,00.
- Jump: pc=8, cmd=11, GET_WORD address 0x00000040 -> pc=0x40; the next FETCH serves mem[16].
- Address wrap with DEPTH=256: store to 0x00000404 -> mem[1] written.
- Errors:
  - FETCH lasting only 2 cycles -> proto_err=1.
  - phase=111 -> proto_err stays 1 and the FSM is IDLE.
  - rst=1 -> proto_err=0 and pc=0.

Source files
------------

// File: rtl/mips_byte_mem_responder.sv
// Byte-serial memory responder for the MIPS IO controller byte bus.
// Serves instruction words from an internal PC, captures 4-byte address/data
// words for store/load/jump transfers and returns load data byte-serially.
// A host port preloads the unified word memory while the bus is idle.
module mips_byte_mem_responder #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    phase,
  input  logic [1:0]    cmd,
  input  logic [7:0]    addr_in,
  input  logic [7:0]    data_in,
  output logic [7:0]    data_out,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic [31:0]   pc,
  output logic          proto_err
);

  localparam logic [2:0] PH_PREPARE    = 3'b000;
  localparam logic [2:0] PH_FETCH      = 3'b001;
  localparam logic [2:0] PH_EXECUTE    = 3'b010;
  localparam logic [2:0] PH_GET_WORD   = 3'b011;
  localparam logic [2:0] PH_WRITE_WORD = 3'b100;
  localparam logic [2:0] PH_STALL      = 3'b101;

  localparam logic [1:0] CMD_STORE = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_JUMP  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPTURE, S_STALL, S_SERVE} state_t;

  // The state for the current cycle follows the controller phase directly;
  // r_state remembers the previous cycle's state to detect leaving FETCH.
  state_t r_state, w_state;
  logic   w_illegal;

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_pc;
  logic [31:0]   r_addr_q;
  logic [31:0]   r_data_q;
  logic [31:0]   r_rd_q;
  logic [2:0]    r_cnt;
  logic          r_err;
  logic          r_load_ok;

  logic [31:0]   w_fetch_word;
  logic [31:0]   w_addr_merge;
  logic [31:0]   w_data_merge;
  logic [4:0]    w_byte_sel;
  logic          w_cnt_lt4;
  logic          w_cap_ok;
  logic          w_cap_last;
  logic          w_store;
  logic          w_host_wr;
  logic          w_mem_we;
  logic          w_leave_fetch;
  logic [AW-1:0] w_cap_idx;
  logic [AW-1:0] w_mem_idx;
  logic [31:0]   w_mem_wdata;

  assign w_cnt_lt4    = (r_cnt < 3'd4);
  assign w_byte_sel   = {r_cnt[1:0], 3'b000};
  assign w_fetch_word = r_mem[r_pc[AW+1:2]];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state;
  end

  // Next-state decode from phase, plus the byte lane back to the controller
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state   = S_IDLE;
    w_illegal = 1'b0;
    data_out  = 8'h00;
    case (phase)
      PH_PREPARE, PH_EXECUTE: w_state = S_IDLE;
      PH_FETCH:               w_state = S_FETCH;
      PH_GET_WORD:            w_state = S_CAPTURE;
      PH_WRITE_WORD:          w_state = S_SERVE;
      PH_STALL:               w_state = S_STALL;
      default:                w_illegal = 1'b1;
    endcase
    case (w_state)
      S_FETCH: if (w_cnt_lt4) data_out = w_fetch_word[w_byte_sel +: 8];
      S_SERVE: if (w_cnt_lt4) data_out = r_rd_q[w_byte_sel +: 8];
      default: data_out = 8'h00;
    endcase
  end

  // Capture words with this cycle's byte merged in, so the cnt=3 action sees the full word
  always_comb begin
    w_addr_merge                  = r_addr_q;
    w_addr_merge[w_byte_sel +: 8] = addr_in;
    w_data_merge                  = r_data_q;
    w_data_merge[w_byte_sel +: 8] = data_in;
  end

  assign w_cap_ok      = (w_state == S_CAPTURE) && w_cnt_lt4 && !r_load_ok;
  assign w_cap_last    = w_cap_ok && (r_cnt == 3'd3);
  assign w_cap_idx     = w_addr_merge[AW+1:2];
  assign w_store       = w_cap_last && (cmd == CMD_STORE);
  assign w_host_wr     = ld_en && (w_state == S_IDLE) && !w_illegal;
  assign w_mem_we      = !rst && (w_store || w_host_wr);
  assign w_mem_idx     = w_store ? w_cap_idx : ld_addr;
  assign w_mem_wdata   = w_store ? w_data_merge : ld_data;
  assign w_leave_fetch = (r_state == S_FETCH) && (w_state != S_FETCH);

  // Single-port word memory write; a bus store takes priority over the host port
  // NOTE: the memory array has no reset so preloaded contents survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
  end

  // Byte counter, PC, capture registers and sticky error flag
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; a later assignment in this block overrides an earlier one.
    if (rst) begin
      r_pc      <= 32'd0;
      r_addr_q  <= 32'd0;
      r_data_q  <= 32'd0;
      r_rd_q    <= 32'd0;
      r_cnt     <= 3'd0;
      r_err     <= 1'b0;
      r_load_ok <= 1'b0;
    end else begin
      if (w_leave_fetch) begin
        if (r_cnt == 3'd4) r_pc  <= r_pc + 32'd4;
        else               r_err <= 1'b1;
      end
      if (w_illegal) r_err <= 1'b1;
      if (ld_en && !w_host_wr) r_err <= 1'b1;
      case (w_state)
        S_IDLE: begin
          r_cnt     <= 3'd0;
          r_load_ok <= 1'b0;
        end
        S_FETCH: begin
          r_load_ok <= 1'b0;
          if (w_cnt_lt4) r_cnt <= r_cnt + 3'd1;
        end
        S_CAPTURE: begin
          if (!w_cap_ok) begin
            r_err <= 1'b1;
          end else begin
            r_addr_q <= w_addr_merge;
            r_data_q <= w_data_merge;
            if (w_cap_last) begin
              case (cmd)
                CMD_STORE: r_cnt <= 3'd4;
                CMD_JUMP: begin
                  r_pc  <= w_addr_merge;
                  r_cnt <= 3'd4;
                end
                CMD_LOAD: begin
                  r_rd_q    <= r_mem[w_cap_idx];
                  r_cnt     <= 3'd0;
                  r_load_ok <= 1'b1;
                end
                default: begin
                  r_err <= 1'b1;
                  r_cnt <= 3'd4;
                end
              endcase
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        S_STALL: begin
          r_cnt <= 3'd0;
          if (!r_load_ok) r_err <= 1'b1;
        end
        S_SERVE: begin
          if (w_cnt_lt4) r_cnt <= r_cnt + 3'd1;
        end
        default: r_cnt <= 3'd0;
      endcase
    end
  end

  assign pc        = r_pc;
  assign proto_err = r_err;

endmodule

// File: tb/tb_mips_byte_mem_responder.sv
// Scoreboard bench for mips_byte_mem_responder: transaction tasks drive the
// byte bus and push expected bytes from a word-level reference model; a
// negedge monitor pops and compares whenever the DUT presents a byte.
module tb_mips_byte_mem_responder;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  localparam logic [2:0] PH_PREPARE    = 3'b000;
  localparam logic [2:0] PH_FETCH      = 3'b001;
  localparam logic [2:0] PH_EXECUTE    = 3'b010;
  localparam logic [2:0] PH_GET_WORD   = 3'b011;
  localparam logic [2:0] PH_WRITE_WORD = 3'b100;
  localparam logic [2:0] PH_STALL      = 3'b101;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_STORE = 2'b01;
  localparam logic [1:0] C_LOAD  = 2'b10;
  localparam logic [1:0] C_JUMP  = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    phase;
  logic [1:0]    cmd;
  logic [7:0]    addr_in;
  logic [7:0]    data_in;
  logic [7:0]    data_out;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic [31:0]   pc;
  logic          proto_err;

  always #5 clk = ~clk;

  mips_byte_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .phase     (phase),
    .cmd       (cmd),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .pc        (pc),
    .proto_err (proto_err)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc;
  logic        m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: bytes presented in FETCH/WRITE_WORD are scored against the queue,
  // every other phase must leave the lane at zero.
  always @(negedge clk) begin
    if (!rst) begin
      if (phase == PH_FETCH || phase == PH_WRITE_WORD) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL data_out: got %h with no expected byte queued", data_out);
        end else begin
          check("data_out", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        end
      end else begin
        check("data_out_idle", {24'd0, data_out}, 32'd0);
      end
    end
  end

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    logic [31:0] s;
    s = w >> (8 * i);
    return s[7:0];
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % DEPTH);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] ph, input logic [1:0] c, input logic [7:0] a, input logic [7:0] d);
    phase   = ph;
    cmd     = c;
    addr_in = a;
    data_in = d;
    ld_en   = 1'b0;
    tick();
  endtask

  task automatic preload(input int idx, input logic [31:0] w);
    phase   = PH_PREPARE;
    ld_en   = 1'b1;
    ld_addr = idx[AW-1:0];
    ld_data = w;
    tick();
    ld_en   = 1'b0;
    m_mem[idx] = w;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    phase = PH_PREPARE;
    ld_en = 1'b0;
    tick();
    rst   = 1'b0;
    m_pc  = 32'd0;
    m_err = 1'b0;
    check("reset_pc", pc, m_pc);
    check("reset_err", {31'd0, proto_err}, {31'd0, m_err});
  endtask

  // PREPARE, n FETCH cycles, then EXECUTE (where the PC advance lands)
  task automatic do_fetch(input int n);
    logic [31:0] w;
    drive(PH_PREPARE, C_NONE, 8'h00, 8'h00);
    w = m_mem[widx(m_pc)];
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(i < 4 ? byte_of(w, i) : 8'h00);
      drive(PH_FETCH, C_NONE, 8'h00, 8'h00);
    end
    if (n >= 4) m_pc = m_pc + 32'd4;
    else        m_err = 1'b1;
    drive(PH_EXECUTE, C_NONE, 8'h00, 8'h00);
  endtask

  // Full memory-transfer instruction: fetch, 4 GET_WORD bytes, load tail
  task automatic do_xfer(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    do_fetch(5);
    for (int i = 0; i < 4; i++) drive(PH_GET_WORD, c, byte_of(a, i), byte_of(d, i));
    case (c)
      C_STORE: m_mem[widx(a)] = d;
      C_JUMP:  m_pc = a;
      C_LOAD: begin
        w = m_mem[widx(a)];
        drive(PH_STALL, c, 8'hFF, 8'h00);
        for (int i = 0; i < 5; i++) begin
          exp_q.push_back(i < 4 ? byte_of(w, i) : 8'h00);
          drive(PH_WRITE_WORD, c, 8'h00, 8'h00);
        end
      end
      default: m_err = 1'b1;
    endcase
    check("xfer_pc", pc, m_pc);
    check("xfer_err", {31'd0, proto_err}, {31'd0, m_err});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  c;
    rst = 1'b1; phase = PH_PREPARE; cmd = C_NONE; addr_in = 8'h00; data_in = 8'h00;
    ld_en = 1'b0; ld_addr = '0; ld_data = 32'd0;
    m_pc = 32'd0; m_err = 1'b0;
    tick(); tick();
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
    preload(0, 32'h8C220004);
    preload(1, 32'h00000000);
    preload(16, 32'hDEADBEEF);
    do_reset();

    // Instruction fetch of mem[0]: 04,00,22,8C,00 then pc=4
    do_fetch(5);
    check("fetch_pc", pc, 32'h4);
    check("fetch_err", {31'd0, proto_err}, 32'd0);

    do_xfer(C_STORE, 32'h00000010, 32'h12345678);
    check("store_mem4", m_mem[4], 32'h12345678);
    do_xfer(C_LOAD, 32'h00000010, 32'h0);

    preload(4, 32'hCAFEBABE);
    do_xfer(C_LOAD, 32'h00000010, 32'h0);

    do_xfer(C_JUMP, 32'h00000040, 32'h0);
    check("jump_pc", pc, 32'h40);
    do_fetch(5);

    // Index wraps modulo DEPTH; low address bits ignored
    do_xfer(C_STORE, 32'h00000404, 32'hA5A55A5A);
    do_xfer(C_LOAD, 32'h00000007, 32'h0);

    // PC wraps modulo 2^32
    do_xfer(C_JUMP, 32'hFFFFFFFC, 32'h0);
    do_fetch(5);
    check("pc_wrap", pc, 32'h0);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      d = $urandom;
      case ($urandom_range(0, 2))
        0:       c = C_STORE;
        1:       c = C_LOAD;
        default: c = C_JUMP;
      endcase
      if ($urandom_range(0, 5) == 0) preload($urandom_range(0, DEPTH - 1), $urandom);
      do_xfer(c, a, d);
    end

    // Reset mid-store: partial capture discarded, memory unchanged
    do_reset();
    do_fetch(5);
    for (int i = 0; i < 3; i++) drive(PH_GET_WORD, C_STORE, byte_of(32'h20, i), byte_of(32'h55AA55AA, i));
    do_reset();
    do_xfer(C_LOAD, 32'h00000020, 32'h0);

    // Fifth GET_WORD cycle: error, store from the 4th cycle still stands
    do_fetch(5);
    for (int i = 0; i < 4; i++) drive(PH_GET_WORD, C_STORE, byte_of(32'h30, i), byte_of(32'h0BADF00D, i));
    m_mem[12] = 32'h0BADF00D;
    drive(PH_GET_WORD, C_STORE, 8'h44, 8'h99);
    check("fifth_get_err", {31'd0, proto_err}, 32'd1);
    do_reset();
    do_xfer(C_LOAD, 32'h00000030, 32'h0);

    // cmd none at end of capture
    do_xfer(C_NONE, 32'h00000050, 32'h1);
    check("cmd_none_err", {31'd0, proto_err}, 32'd1);
    do_reset();

    // STALL without a load
    do_fetch(5);
    drive(PH_STALL, C_NONE, 8'hFF, 8'h00);
    check("stall_err", {31'd0, proto_err}, 32'd1);
    do_reset();

    // Short fetch: error, pc unchanged
    do_fetch(2);
    check("short_fetch_err", {31'd0, proto_err}, 32'd1);
    check("short_fetch_pc", pc, 32'h0);

    // Illegal phase keeps the sticky flag and idles the lane
    drive(3'b111, C_NONE, 8'h00, 8'h00);
    check("illegal_err", {31'd0, proto_err}, 32'd1);
    drive(3'b110, C_NONE, 8'h00, 8'h00);
    check("illegal_err2", {31'd0, proto_err}, 32'd1);

    do_reset();
    check("final_err", {31'd0, proto_err}, 32'd0);
    check("final_pc", pc, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
